// File: rtl/cmos_cfg_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cmos_cfg_pkg
//  Description : Shared state encodings and SCCB constants for the camera
//                register configuration sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package cmos_cfg_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_FETCH = 3'd1;
    localparam state_t ST_ISSUE = 3'd2;
    localparam state_t ST_WAIT  = 3'd3;
    localparam state_t ST_DELAY = 3'd4;
    localparam state_t ST_NEXT  = 3'd5;
    localparam state_t ST_DONE  = 3'd6;
    localparam state_t ST_ERROR = 3'd7;

    localparam logic SCCB_WR = 1'b0;
    localparam logic SCCB_RD = 1'b1;

    localparam logic [7:0] DELAY_MARK_DEF = 8'hFF;

endpackage
`default_nettype wire

// File: rtl/cmos_cfg_sequencer_delay_timer.sv
`default_nettype none
// ============================================================================
//  Module      : cfg_delay_timer
//  Description : Loadable down-counter; pulses expired on the last enabled
//                cycle of a non-zero load.
//  Revision    : 1.0 - initial release
// ============================================================================
module cfg_delay_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             expired
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en && (count_q != '0)) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // A load of N gives exactly N enabled cycles before the pulse ends them.
    assign expired = en && (count_q == CNT_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/cmos_cfg_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : cmos_cfg_sequencer
//  Description : Walks a {reg,data} LUT, issuing one SCCB transaction per
//                entry with ID check, optional readback, delays and retries.
//  Revision    : 1.0 - initial release
// ============================================================================
module cmos_cfg_sequencer
    import cmos_cfg_pkg::*;
#(
    parameter int         LUT_SIZE   = 171,
    parameter int         IDX_W      = 8,
    parameter int         ID_CNT     = 2,
    parameter logic [7:0] DEV_ADDR   = 8'h42,
    parameter int         VERIFY     = 0,
    parameter int         RETRY_MAX  = 3,
    parameter logic [7:0] DELAY_MARK = DELAY_MARK_DEF,
    parameter int         DELAY_UNIT = 50000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [IDX_W-1:0] lut_index,
    input  logic [15:0]      lut_data,
    output logic             sccb_req,
    output logic             sccb_rd,
    output logic [7:0]       sccb_dev,
    output logic [7:0]       sccb_reg,
    output logic [7:0]       sccb_wdata,
    input  logic             sccb_ack,
    input  logic             sccb_nack,
    input  logic [7:0]       sccb_rdata,
    output logic             cfg_busy,
    output logic             cfg_done,
    output logic             cfg_err,
    output logic [IDX_W-1:0] err_index
);

    localparam int               DLY_W    = (DELAY_UNIT < 1) ? 1 : $clog2(255 * DELAY_UNIT + 1);
    localparam int               RTY_W    = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);
    localparam logic [RTY_W-1:0] RTY_LIM  = RTY_W'(RETRY_MAX);
    localparam logic [IDX_W:0]   ID_LIM   = (IDX_W + 1)'(ID_CNT);
    localparam logic [IDX_W:0]   SIZE_LIM = (IDX_W + 1)'(LUT_SIZE);
    localparam logic [DLY_W-1:0] UNIT_V   = DLY_W'(DELAY_UNIT);
    localparam logic [7:0]       DEV_RD   = DEV_ADDR | 8'h01;

    state_t             state_q,      state_d;
    logic [IDX_W-1:0]   lut_index_q,  lut_index_d;
    logic [7:0]         cur_reg_q,    cur_reg_d;
    logic [7:0]         cur_dat_q,    cur_dat_d;
    logic               id_rd_q,      id_rd_d;
    logic               vphase_q,     vphase_d;
    logic [RTY_W-1:0]   retry_q,      retry_d;
    logic               sccb_req_q,   sccb_req_d;
    logic               sccb_rd_q,    sccb_rd_d;
    logic [7:0]         sccb_dev_q,   sccb_dev_d;
    logic [7:0]         sccb_reg_q,   sccb_reg_d;
    logic [7:0]         sccb_wdata_q, sccb_wdata_d;
    logic               cfg_busy_q,   cfg_busy_d;
    logic               cfg_done_q,   cfg_done_d;
    logic               cfg_err_q,    cfg_err_d;
    logic [IDX_W-1:0]   err_index_q,  err_index_d;

    logic               dly_load;
    logic               dly_en;
    logic               dly_expired;
    logic [DLY_W-1:0]   dly_val;
    logic [IDX_W:0]     next_idx;
    logic               xfer_fail;

    // One bit wider than the index so LUT_SIZE == 2**IDX_W still terminates.
    assign next_idx  = {1'b0, lut_index_q} + {{IDX_W{1'b0}}, 1'b1};
    assign xfer_fail = sccb_nack || ((sccb_rd_q == SCCB_RD) && (sccb_rdata != cur_dat_q));
    assign dly_val   = DLY_W'(lut_data[7:0]) * UNIT_V;
    assign dly_en    = (state_q == ST_DELAY);

    cfg_delay_timer #(
        .CNT_W (DLY_W)
    ) u_delay_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (dly_load),
        .load_val (dly_val),
        .en       (dly_en),
        .expired  (dly_expired)
    );

    always_comb begin
        state_d      = state_q;
        lut_index_d  = lut_index_q;
        cur_reg_d    = cur_reg_q;
        cur_dat_d    = cur_dat_q;
        id_rd_d      = id_rd_q;
        vphase_d     = vphase_q;
        retry_d      = retry_q;
        sccb_req_d   = sccb_req_q;
        sccb_rd_d    = sccb_rd_q;
        sccb_dev_d   = sccb_dev_q;
        sccb_reg_d   = sccb_reg_q;
        sccb_wdata_d = sccb_wdata_q;
        cfg_busy_d   = cfg_busy_q;
        cfg_done_d   = cfg_done_q;
        cfg_err_d    = cfg_err_q;
        err_index_d  = err_index_q;
        dly_load     = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    state_d     = ST_FETCH;
                    lut_index_d = '0;
                    retry_d     = '0;
                    vphase_d    = 1'b0;
                    cfg_done_d  = 1'b0;
                    cfg_err_d   = 1'b0;
                    cfg_busy_d  = 1'b1;
                end
            end

            ST_FETCH: begin
                cur_reg_d = lut_data[15:8];
                cur_dat_d = lut_data[7:0];
                vphase_d  = 1'b0;
                id_rd_d   = ({1'b0, lut_index_q} < ID_LIM);
                if ({1'b0, lut_index_q} < ID_LIM) begin
                    state_d = ST_ISSUE;
                end else if (lut_data[15:8] == DELAY_MARK) begin
                    if (lut_data[7:0] == 8'h00) begin
                        state_d = ST_NEXT;
                    end else begin
                        dly_load = 1'b1;
                        state_d  = ST_DELAY;
                    end
                end else begin
                    state_d = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                sccb_req_d   = 1'b1;
                sccb_rd_d    = (id_rd_q || vphase_q) ? SCCB_RD : SCCB_WR;
                sccb_dev_d   = (id_rd_q || vphase_q) ? DEV_RD : DEV_ADDR;
                sccb_reg_d   = cur_reg_q;
                sccb_wdata_d = cur_dat_q;
                state_d      = ST_WAIT;
            end

            ST_WAIT: begin
                if (sccb_ack) begin
                    sccb_req_d = 1'b0;
                    if (xfer_fail) begin
                        // A failed readback restarts from the write, not just the read.
                        if (retry_q < RTY_LIM) begin
                            retry_d  = retry_q + RTY_W'(1);
                            vphase_d = 1'b0;
                            state_d  = ST_ISSUE;
                        end else begin
                            cfg_err_d   = 1'b1;
                            err_index_d = lut_index_q;
                            cfg_busy_d  = 1'b0;
                            state_d     = ST_ERROR;
                        end
                    end else if ((sccb_rd_q == SCCB_WR) && (VERIFY != 0)) begin
                        vphase_d = 1'b1;
                        state_d  = ST_ISSUE;
                    end else begin
                        state_d = ST_NEXT;
                    end
                end
            end

            ST_DELAY: begin
                if (dly_expired) begin
                    state_d = ST_NEXT;
                end
            end

            ST_NEXT: begin
                retry_d     = '0;
                lut_index_d = next_idx[IDX_W-1:0];
                if (next_idx == SIZE_LIM) begin
                    cfg_done_d = 1'b1;
                    cfg_busy_d = 1'b0;
                    state_d    = ST_DONE;
                end else begin
                    state_d = ST_FETCH;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            lut_index_q  <= '0;
            cur_reg_q    <= '0;
            cur_dat_q    <= '0;
            id_rd_q      <= 1'b0;
            vphase_q     <= 1'b0;
            retry_q      <= '0;
            sccb_req_q   <= 1'b0;
            sccb_rd_q    <= 1'b0;
            sccb_dev_q   <= DEV_ADDR;
            sccb_reg_q   <= '0;
            sccb_wdata_q <= '0;
            cfg_busy_q   <= 1'b0;
            cfg_done_q   <= 1'b0;
            cfg_err_q    <= 1'b0;
            err_index_q  <= '0;
        end else begin
            state_q      <= state_d;
            lut_index_q  <= lut_index_d;
            cur_reg_q    <= cur_reg_d;
            cur_dat_q    <= cur_dat_d;
            id_rd_q      <= id_rd_d;
            vphase_q     <= vphase_d;
            retry_q      <= retry_d;
            sccb_req_q   <= sccb_req_d;
            sccb_rd_q    <= sccb_rd_d;
            sccb_dev_q   <= sccb_dev_d;
            sccb_reg_q   <= sccb_reg_d;
            sccb_wdata_q <= sccb_wdata_d;
            cfg_busy_q   <= cfg_busy_d;
            cfg_done_q   <= cfg_done_d;
            cfg_err_q    <= cfg_err_d;
            err_index_q  <= err_index_d;
        end
    end

    assign lut_index  = lut_index_q;
    assign sccb_req   = sccb_req_q;
    assign sccb_rd    = sccb_rd_q;
    assign sccb_dev   = sccb_dev_q;
    assign sccb_reg   = sccb_reg_q;
    assign sccb_wdata = sccb_wdata_q;
    assign cfg_busy   = cfg_busy_q;
    assign cfg_done   = cfg_done_q;
    assign cfg_err    = cfg_err_q;
    assign err_index  = err_index_q;

endmodule
`default_nettype wire
